// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit and its controller: access
// op encodings, FSM states and small decode helpers.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_store(input op_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // Every 3-bit code is assigned today; the default arm keeps the decode
    // safe if the op field is ever widened.
    function automatic logic is_known(input op_t op);
        logic known;
        case (op)
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB: known = 1'b1;
            default: known = 1'b0;
        endcase
        return known;
    endfunction

    function automatic logic is_word(input op_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input op_t op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    // True when the low address bits do not match the natural alignment of the access size.
    function automatic logic is_misaligned(input op_t op, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if (is_word(op))      mis = (lo != 2'b00);
        else if (is_half(op)) mis = lo[0];
        return mis;
    endfunction

    // Clears the low address bits that a word or half access must not use.
    function automatic logic [1:0] align_low(input op_t op, input logic [1:0] lo);
        logic [1:0] res;
        res = lo;
        if (is_word(op))      res = 2'b00;
        else if (is_half(op)) res = {lo[1], 1'b0};
        return res;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide data memory bus with a req/ack handshake. The access unit is the
// master; the memory (or its model) is the slave.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit_store_lane_pack.sv
// Store lane packer: turns a store op, the low address bits and the 32-bit
// register value into byte enables and lane-replicated write data.
// Loads read the whole word, so they get all enables and no data.
module store_lane_pack
    import mem_access_pkg::*;
(
    input  op_t         op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] data
);

    // Replicate the source lane across the word and enable only the addressed bytes.
    always_comb begin
        be   = 4'b1111;
        data = '0;
        case (op)
            OP_SW: data = wdata;
            OP_SH: begin
                data = {2{wdata[15:0]}};
                be   = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            OP_SB: begin
                data = {4{wdata[7:0]}};
                be   = 4'b0001 << addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Sequential load/store bridge between the MEM stage and a word-wide data
// memory. One access at a time: IDLE -> REQ -> DONE -> IDLE, with busy
// stalling the pipeline. Define MISALIGN_TRAP_EN to trap misaligned
// word/half accesses instead of silently aligning them.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  op_t               op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_out,
    output logic              done,
    output logic              busy,
    mem_access_unit_if.master mem,
    output logic              exc_adel,
    output logic              exc_ades
);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              misalign;
    logic [1:0]        accept_lo;
    logic [31:0]       load_ext;
    logic [3:0]        pack_be;
    logic [31:0]       pack_data;

`ifdef MISALIGN_TRAP_EN
    logic trap_q, trap_d;

    assign misalign  = is_misaligned(op, addr[1:0]);
    assign accept_lo = addr[1:0];

    // Remember whether the accepted access trapped so the exception pulses with done.
    always_comb begin
        trap_d = trap_q;
        if (state_q == IDLE && op_valid) trap_d = misalign;
    end

    // Trap flag register.
    always_ff @(posedge clk) begin
        if (!reset) trap_q <= 1'b0;
        else        trap_q <= trap_d;
    end

    assign exc_adel = (state_q == DONE) && trap_q && !is_store(op_q);
    assign exc_ades = (state_q == DONE) && trap_q &&  is_store(op_q);
`else
    assign misalign  = 1'b0;
    assign accept_lo = align_low(op, addr[1:0]);
    assign exc_adel  = 1'b0;
    assign exc_ades  = 1'b0;
`endif

    store_lane_pack u_pack (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .wdata   (wdata_q),
        .be      (pack_be),
        .data    (pack_data)
    );

    // Pick the addressed byte or half out of the returned word and extend it.
    always_comb begin
        logic [15:0] half_sel;
        logic [7:0]  byte_sel;
        half_sel = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (addr_q[1:0])
            2'd0:    byte_sel = mem.mem_rdata[7:0];
            2'd1:    byte_sel = mem.mem_rdata[15:8];
            2'd2:    byte_sel = mem.mem_rdata[23:16];
            default: byte_sel = mem.mem_rdata[31:24];
        endcase
        case (op_q)
            OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_ext = {16'h0000, half_sel};
            OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_ext = {24'h000000, byte_sel};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    // State and access registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state: accept in IDLE, wait for ack in REQ, single-cycle DONE.
    // Trapped and unknown ops skip the memory and finish with a zero load result.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_d    = op;
                    addr_d  = {addr[ADDR_W-1:2], accept_lo};
                    wdata_d = wdata;
                    if (!is_known(op) || misalign) begin
                        state_d = DONE;
                        if (!is_store(op)) rdata_d = '0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    state_d = DONE;
                    if (!is_store(op_q)) rdata_d = load_ext;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state; bus fields are driven only while requesting.
    always_comb begin
        op_ready      = (state_q == IDLE);
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        mem.mem_req   = (state_q == REQ);
        mem.mem_we    = 1'b0;
        mem.mem_be    = 4'b0000;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (state_q == REQ) begin
            mem.mem_we    = is_store(op_q);
            mem.mem_be    = pack_be;
            mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            mem.mem_wdata = pack_data;
        end
    end

    assign rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases with literal
// expectations plus randomized accesses against a behavioural model that
// predicts every cycle of the handshake. Follows MISALIGN_TRAP_EN if defined.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    op_t         op;
    logic [31:0] addr, wdata, rdata_out;
    logic        op_ready, done, busy, exc_adel, exc_ades;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .rdata_out (rdata_out),
        .done      (done),
        .busy      (busy),
        .mem       (mem_if),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit          check_en = 0;
    bit          exp_busy, exp_req, exp_done, exp_we, exp_adel, exp_ades, exp_in_reset;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, model_rdata;

    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata, cap_rdata;
    logic        cap_we, cap_adel, cap_ades;
    int          done_count = 0;
    int          req_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit trapOn();
`ifdef MISALIGN_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit isStoreOp(input op_t o);
        return (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
    endfunction

    function automatic int unsigned accSize(input op_t o);
        if (o == OP_LW || o == OP_SW) return 4;
        if (o == OP_LH || o == OP_LHU || o == OP_SH) return 2;
        return 1;
    endfunction

    function automatic logic [3:0] expBe(input op_t o, input logic [31:0] ea);
        if (o == OP_SW) return 4'hF;
        if (o == OP_SH) return 4'h3 << (ea % 4);
        if (o == OP_SB) return 4'h1 << (ea % 4);
        return 4'hF;
    endfunction

    function automatic logic [31:0] expWdata(input op_t o, input logic [31:0] w);
        if (o == OP_SW) return w;
        if (o == OP_SH) return (w & 32'h0000_FFFF) * 32'h0001_0001;
        if (o == OP_SB) return (w & 32'h0000_00FF) * 32'h0101_0101;
        return 32'h0;
    endfunction

    function automatic logic [31:0] expLoad(input op_t o, input logic [31:0] ea, input logic [31:0] word);
        logic [31:0] v;
        v = word >> ((ea % 4) * 8);
        if (o == OP_LH || o == OP_LHU) begin
            v = v & 32'h0000_FFFF;
            if (o == OP_LH && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
            return v;
        end
        if (o == OP_LB || o == OP_LBU) begin
            v = v & 32'h0000_00FF;
            if (o == OP_LB && v >= 32'h0000_0080) v = v | 32'hFFFF_FF00;
            return v;
        end
        return word;
    endfunction

    // Compare every DUT output against the model each cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkBit("busy", busy, exp_busy);
            checkBit("op_ready", op_ready, !exp_busy);
            checkBit("done", done, exp_done);
            checkBit("mem_req", mem_if.mem_req, exp_req);
            checkBit("exc_adel", exc_adel, exp_adel);
            checkBit("exc_ades", exc_ades, exp_ades);
            if (exp_req) begin
                checkBit("mem_we", mem_if.mem_we, exp_we);
                checkOutput("mem_be", {28'h0, mem_if.mem_be}, {28'h0, exp_be});
                checkOutput("mem_addr", mem_if.mem_addr, exp_addr);
                if (exp_we) checkOutput("mem_wdata", mem_if.mem_wdata, exp_wdata);
            end
            if (exp_done) checkOutput("rdata_out", rdata_out, model_rdata);
            if (exp_in_reset) begin
                checkOutput("rst_rdata_out", rdata_out, 32'h0);
                checkOutput("rst_mem_addr", mem_if.mem_addr, 32'h0);
                checkOutput("rst_mem_wdata", mem_if.mem_wdata, 32'h0);
                checkOutput("rst_mem_be", {28'h0, mem_if.mem_be}, 32'h0);
                checkBit("rst_mem_we", mem_if.mem_we, 1'b0);
            end
            if (mem_if.mem_req) begin
                req_count++;
                cap_be    = mem_if.mem_be;
                cap_addr  = mem_if.mem_addr;
                cap_wdata = mem_if.mem_wdata;
                cap_we    = mem_if.mem_we;
            end
            if (done) begin
                done_count++;
                cap_rdata = rdata_out;
                cap_adel  = exc_adel;
                cap_ades  = exc_ades;
            end
        end
    end

    // One complete access: present it, answer the request after ack_delay wait cycles, then drop op_valid on completion.
    task automatic applyStimulus(input op_t o, input logic [31:0] a, input logic [31:0] w,
                                 input int ack_delay, input logic [31:0] word);
        logic [31:0] ea;
        bit mis;
        mis = trapOn() && ((a % accSize(o)) != 0);
        ea  = trapOn() ? a : (a - (a % accSize(o)));
        op_valid = 1'b1;
        op       = o;
        addr     = a;
        wdata    = w;
        mem_if.mem_ack   = 1'($urandom_range(0, 1));
        mem_if.mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
        exp_busy = 1'b1;
        if (mis) begin
            exp_done = 1'b1;
            exp_adel = !isStoreOp(o);
            exp_ades = isStoreOp(o);
            if (!isStoreOp(o)) model_rdata = 32'h0;
        end else begin
            exp_req   = 1'b1;
            exp_we    = isStoreOp(o);
            exp_be    = expBe(o, ea);
            exp_addr  = ea & 32'hFFFF_FFFC;
            exp_wdata = expWdata(o, w);
            for (int i = 0; i <= ack_delay; i++) begin
                mem_if.mem_ack   = (i == ack_delay);
                mem_if.mem_rdata = (i == ack_delay) ? word : $urandom;
                @(posedge clk); #1;
            end
            exp_req  = 1'b0;
            exp_done = 1'b1;
            if (!isStoreOp(o)) model_rdata = expLoad(o, ea, word);
        end
        op_valid = 1'b0;
        mem_if.mem_ack   = 1'($urandom_range(0, 1));
        mem_if.mem_rdata = $urandom;
        @(posedge clk); #1;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_adel = 1'b0;
        exp_ades = 1'b0;
        mem_if.mem_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0, r0;
        reset = 1'b0;
        op_valid = 1'b0;
        op = OP_LW;
        addr = 32'h0;
        wdata = 32'h0;
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rdata = 32'h0;
        {exp_busy, exp_req, exp_done, exp_we, exp_adel, exp_ades} = '0;
        exp_be = 4'h0; exp_addr = 32'h0; exp_wdata = 32'h0; model_rdata = 32'h0;
        exp_in_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_in_reset = 1'b0;
        @(posedge clk); #1;

        // SW with two wait cycles
        d0 = done_count;
        applyStimulus(OP_SW, 32'h0000_1004, 32'hDEAD_BEEF, 2, 32'h0);
        checkOutput("t1_addr", cap_addr, 32'h0000_1004);
        checkOutput("t1_be", {28'h0, cap_be}, 32'hF);
        checkOutput("t1_wdata", cap_wdata, 32'hDEAD_BEEF);
        checkOutput("t1_done_pulses", done_count - d0, 1);

        // SB to the top byte lane
        applyStimulus(OP_SB, 32'h0000_2003, 32'h1234_56A5, 0, 32'h0);
        checkOutput("t2_be", {28'h0, cap_be}, 32'h8);
        checkOutput("t2_wdata", cap_wdata, 32'hA5A5_A5A5);
        checkBit("t2_we", cap_we, 1'b1);

        // Byte and half loads, signed and unsigned
        applyStimulus(OP_LB, 32'h0000_3001, 32'h0, 1, 32'h0000_8000);
        checkOutput("t3_lb", cap_rdata, 32'hFFFF_FF80);
        checkBit("t3_we", cap_we, 1'b0);
        applyStimulus(OP_LBU, 32'h0000_3001, 32'h0, 0, 32'h0000_8000);
        checkOutput("t3_lbu", cap_rdata, 32'h0000_0080);
        applyStimulus(OP_LH, 32'h0000_4002, 32'h0, 3, 32'h8001_1234);
        checkOutput("t4_lh", cap_rdata, 32'hFFFF_8001);
        checkOutput("t4_be", {28'h0, cap_be}, 32'hF);
        applyStimulus(OP_LHU, 32'h0000_4002, 32'h0, 0, 32'h8001_1234);
        checkOutput("t4_lhu", cap_rdata, 32'h0000_8001);

        // Misaligned LW
        r0 = req_count;
        d0 = done_count;
        applyStimulus(OP_LW, 32'h0000_5002, 32'h0, 1, 32'hCAFE_F00D);
        checkOutput("t5_done_pulses", done_count - d0, 1);
`ifdef MISALIGN_TRAP_EN
        checkOutput("t5_req_cycles", req_count - r0, 0);
        checkBit("t5_adel", cap_adel, 1'b1);
        checkOutput("t5_rdata", cap_rdata, 32'h0);
`else
        checkOutput("t5_req_cycles", req_count - r0, 2);
        checkOutput("t5_addr", cap_addr, 32'h0000_5000);
        checkOutput("t5_rdata", cap_rdata, 32'hCAFE_F00D);
        checkBit("t5_adel", cap_adel, 1'b0);
`endif

        // Reset while waiting for ack abandons the access
        d0 = done_count;
        op_valid = 1'b1; op = OP_SW; addr = 32'h0000_6000; wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        exp_busy = 1'b1; exp_req = 1'b1; exp_we = 1'b1; exp_be = 4'hF;
        exp_addr = 32'h0000_6000; exp_wdata = 32'h0BAD_F00D;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; op_valid = 1'b0;
        exp_busy = 1'b0; exp_req = 1'b0; model_rdata = 32'h0;
        checkBit("t6_req_dropped", mem_if.mem_req, 1'b0);
        checkBit("t6_busy_dropped", busy, 1'b0);
        @(posedge clk); #1;
        checkOutput("t6_no_done", done_count - d0, 0);
        applyStimulus(OP_SW, 32'h0000_6010, 32'h5555_AAAA, 1, 32'h0);
        checkOutput("t6_sw_done", done_count - d0, 1);
        checkOutput("t6_sw_wdata", cap_wdata, 32'h5555_AAAA);

        // Randomized accesses with occasional idle gaps
        for (int n = 0; n < 300; n++) begin
            applyStimulus(op_t'($urandom_range(0, 7)), $urandom, $urandom,
                          int'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                mem_if.mem_ack = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                mem_if.mem_ack = 1'b0;
            end
        end

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
